// File: rtl/cpu_pkg.sv
// Shared definitions for the semi-CPU control path: phase codes and their width.
package cpu_pkg;

  localparam int PHASE_W = 3;

  localparam logic [PHASE_W-1:0] PHASE_IDLE    = 3'd0;
  localparam logic [PHASE_W-1:0] PHASE_FETCH   = 3'd1;
  localparam logic [PHASE_W-1:0] PHASE_DECODE  = 3'd2;
  localparam logic [PHASE_W-1:0] PHASE_EXECUTE = 3'd3;
  localparam logic [PHASE_W-1:0] PHASE_WB      = 3'd4;
  localparam logic [PHASE_W-1:0] PHASE_HALTED  = 3'd7;

  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE    = PHASE_IDLE,
    ST_FETCH   = PHASE_FETCH,
    ST_DECODE  = PHASE_DECODE,
    ST_EXECUTE = PHASE_EXECUTE,
    ST_WB      = PHASE_WB,
    ST_HALTED  = PHASE_HALTED
  } phase_e;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw push button and accepts a new level only after it has been
// stable for DEBOUNCE_CYCLES cycles; emits a one-cycle pulse on each accepted press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synced input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/cpu_step_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the semi-CPU, started by a
// debounced step button or a free-running tick; HALT parks it until reset.
module cpu_step_sequencer
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RUN_DIV         = 50_000_000,
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_btn,
  input  logic               run_mode,
  input  logic               halt_instr,
  input  logic               reg_write,
  output logic               ir_load,
  output logic               alu_latch,
  output logic               rf_we,
  output logic               pc_inc,
  output logic               busy,
  output logic               halted,
  output logic [PHASE_W-1:0] phase,
  output logic [CNT_W-1:0]   retired
);

  localparam int PW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(RUN_DIV - 1);

  logic           btn_level;
  logic           step_pulse;
  logic [PW-1:0]  pre_q, pre_d;
  logic           run_tick;
  logic           trigger;
  phase_e         state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (step_btn),
    .level     (btn_level),
    .rise_pulse(step_pulse)
  );

  // Prescaler is parked at 0 in single-step mode so run mode always starts a full period.
  assign run_tick = run_mode && (pre_q == PRE_MAX);
  assign trigger  = run_mode ? run_tick : step_pulse;

  always_comb begin
    pre_d = '0;
    if (run_mode) begin
      pre_d = run_tick ? '0 : pre_q + 1'b1;
    end
  end

  // Triggers outside IDLE are simply ignored rather than remembered.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (trigger) state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE:  state_d = halt_instr ? ST_HALTED : ST_EXECUTE;
      ST_EXECUTE: state_d = ST_WB;
      ST_WB:      state_d = ST_IDLE;
      ST_HALTED:  state_d = ST_HALTED;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (state_q == ST_WB) begin
      retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      retired_q <= retired_d;
    end
  end

  assign ir_load   = (state_q == ST_FETCH);
  assign alu_latch = (state_q == ST_EXECUTE);
  assign pc_inc    = (state_q == ST_WB);
  assign rf_we     = (state_q == ST_WB) && reg_write;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                     (state_q == ST_EXECUTE) || (state_q == ST_WB);
  assign halted    = (state_q == ST_HALTED);
  assign phase     = state_q;
  assign retired   = retired_q;

  logic unused_level;
  assign unused_level = btn_level;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed scenarios plus a randomized soak for cpu_step_sequencer, checked each cycle
// against a cycle-count reference model of the instruction sequencing rules.
module tb_cpu_step_sequencer;

  localparam int D   = 4;
  localparam int RD  = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset, step_btn, run_mode, halt_instr, reg_write;
  logic          ir_load, alu_latch, rf_we, pc_inc, busy, halted;
  logic [2:0]    phase;
  logic [CW-1:0] retired;

  cpu_step_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .RUN_DIV        (RD),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .step_btn  (step_btn),
    .run_mode  (run_mode),
    .halt_instr(halt_instr),
    .reg_write (reg_write),
    .ir_load   (ir_load),
    .alu_latch (alu_latch),
    .rf_we     (rf_we),
    .pc_inc    (pc_inc),
    .busy      (busy),
    .halted    (halted),
    .phase     (phase),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: button history, debounce run length, and instruction age
  // (cycles since FETCH; -1 when idle).
  int m_s1, m_s2, m_level, m_stable, m_pulse, m_pre, m_age, m_halted, m_retired;

  int ev_fetch, ev_pc, ev_rf, last_fetch_cyc, last_pc_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_stable = 0; m_pulse = 0;
    m_pre = 0; m_age = -1; m_halted = 0; m_retired = 0;
  endtask

  task automatic model_advance();
    int trig;
    if (reset) begin
      model_reset();
    end else begin
      trig = run_mode ? int'(m_pre == RD - 1) : m_pulse;
      if (m_halted == 0) begin
        if (m_age < 0) begin
          if (trig != 0) m_age = 0;
        end else if (m_age == 1 && halt_instr) begin
          m_halted = 1;
          m_age    = -1;
        end else if (m_age == 3) begin
          m_retired = (m_retired + 1) % (1 << CW);
          m_age     = -1;
        end else begin
          m_age++;
        end
      end
      m_pre   = run_mode ? (m_pre + 1) % RD : 0;
      m_pulse = 0;
      if (m_s2 != m_level) begin
        if (m_stable == D - 1) begin
          m_level  = 1 - m_level;
          m_stable = 0;
          m_pulse  = m_level;
        end else begin
          m_stable++;
        end
      end else begin
        m_stable = 0;
      end
      m_s2 = m_s1;
      m_s1 = int'(step_btn);
    end
  endtask

  task automatic step_cycle();
    int          ph;
    logic [12:0] exp_v;
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
    ph = (m_halted != 0) ? 7 : ((m_age < 0) ? 0 : m_age + 1);
    exp_v = {3'(ph), 1'(ph >= 1 && ph <= 4), 1'(ph == 7), 1'(ph == 1), 1'(ph == 3),
             1'(ph == 4 && reg_write), 1'(ph == 4), CW'(m_retired)};
    check("cycle_outputs",
          32'({phase, busy, halted, ir_load, alu_latch, rf_we, pc_inc, retired}),
          32'(exp_v));
    if (ir_load) begin ev_fetch++; last_fetch_cyc = cyc; end
    if (pc_inc)  begin ev_pc++;    last_pc_cyc    = cyc; end
    if (rf_we)   ev_rf++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic clear_ev();
    ev_fetch = 0; ev_pc = 0; ev_rf = 0; last_fetch_cyc = 0; last_pc_cyc = 0;
  endtask

  task automatic press(input int hi, input int lo);
    step_btn = 1'b1; run(hi);
    step_btn = 1'b0; run(lo);
  endtask

  task automatic wait_phase(input int ph, input int budget);
    for (int i = 0; i < budget && phase != 3'(ph); i++) step_cycle();
    check("wait_phase", 32'(phase), 32'(ph));
  endtask

  initial begin
    int hold_left;
    model_reset();
    clear_ev();
    reset = 1'b1; step_btn = 1'b0; run_mode = 1'b0; halt_instr = 1'b0; reg_write = 1'b1;
    run(2);
    check("reset_phase", 32'(phase), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    reset = 1'b0;

    // T1: long press -> exactly one instruction, WB three cycles after FETCH
    clear_ev();
    press(10, 15);
    check("t1_fetch_count", ev_fetch, 1);
    check("t1_pc_inc_count", ev_pc, 1);
    check("t1_rf_we_count", ev_rf, 1);
    check("t1_wb_latency", last_pc_cyc - last_fetch_cyc, 3);
    check("t1_retired", 32'(retired), 32'd1);

    // T2: bouncing input must not step; settled level steps once
    clear_ev();
    for (int i = 0; i < 12; i++) begin
      step_btn = ((i / 2) % 2) == 0;
      run(1);
    end
    check("t2_bounce_fetch", ev_fetch, 0);
    press(12, 12);
    check("t2_settled_fetch", ev_fetch, 1);
    check("t2_retired", 32'(retired), 32'd2);

    // T3: HALT is sticky, uncounted, and produces no pc_inc
    halt_instr = 1'b1;
    clear_ev();
    press(8, 12);
    check("t3_halted", 32'(halted), 32'd1);
    check("t3_phase", 32'(phase), 32'd7);
    check("t3_retired", 32'(retired), 32'd2);
    check("t3_pc_inc", ev_pc, 0);
    halt_instr = 1'b0;
    clear_ev();
    press(8, 12);
    check("t3_no_fetch_when_halted", ev_fetch, 0);
    reset = 1'b1; run(1); reset = 1'b0;
    check("t3_reset_phase", 32'(phase), 32'd0);
    check("t3_reset_halted", 32'(halted), 32'd0);

    // T4: run mode, one instruction per 8-cycle tick
    reg_write = 1'b0;
    clear_ev();
    run_mode = 1'b1; run(40);
    run_mode = 1'b0; run(10);
    check("t4_retired", 32'(retired), 32'd5);
    check("t4_pc_inc", ev_pc, 5);
    check("t4_rf_we", ev_rf, 0);

    // T5: reset in EXECUTE aborts the instruction
    reg_write = 1'b1;
    reset = 1'b1; run(1); reset = 1'b0;
    clear_ev();
    press(6, 0);
    wait_phase(3, 20);
    reset = 1'b1; run(1);
    check("t5_phase_after_reset", 32'(phase), 32'd0);
    check("t5_strobes_after_reset", 32'({ir_load, alu_latch, rf_we, pc_inc}), 32'd0);
    reset = 1'b0;
    run(12);
    check("t5_pc_inc", ev_pc, 0);
    check("t5_rf_we", ev_rf, 0);
    check("t5_retired", 32'(retired), 32'd0);

    // T6: retired counter wraps 15 -> 0
    clear_ev();
    for (int i = 0; i < 15; i++) press(6, 10);
    check("t6_retired_15", 32'(retired), 32'd15);
    press(6, 10);
    check("t6_retired_wrap", 32'(retired), 32'd0);
    check("t6_pc_inc", ev_pc, 16);

    // T7: run tick starts an instruction, a step pulse lands in DECODE and is dropped
    reset = 1'b1; run(1); reset = 1'b0;
    clear_ev();
    run_mode = 1'b1; run(3);
    step_btn = 1'b1; run(5);
    run_mode = 1'b0; run(1);
    step_btn = 1'b0; run(15);
    check("t7_fetch_count", ev_fetch, 1);
    check("t7_retired", 32'(retired), 32'd1);
    check("t7_pc_inc", ev_pc, 1);

    // Randomized soak against the model
    reset = 1'b1; run(1); reset = 1'b0;
    hold_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold_left == 0) begin
        step_btn  = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 12);
      end
      hold_left--;
      if ($urandom_range(0, 59) == 0) run_mode = ~run_mode;
      halt_instr = ($urandom_range(0, 15) == 0);
      reg_write  = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 299) == 0);
      step_cycle();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
